move_command_sequencer: RTL and testbench

//  Sits between ir_receiver and motor_signal_stream on the rover (25 MHz domain).

---
 rtl/move_command_sequencer_pkg.sv | 20 ++
 rtl/move_command_sequencer_cmd_fifo.sv | 58 +++++
 rtl/move_command_sequencer.sv | 146 ++++++++++++++
 tb/tb_move_command_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/move_command_sequencer_pkg.sv
// Shared command width, stop encoding and sequencer state encodings for the rover
// command path, plus a counter-width helper.
package move_command_sequencer_pkg;

  localparam int CMD_W = 12;
  localparam logic [CMD_W-1:0] CMD_STOP = 12'h000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/move_command_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; head is read straight from the storage
// registers so the oldest entry is visible without a read cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/move_command_sequencer.sv
// Buffers IR move commands, drops repeat duplicates and feeds the motor stream one
// move at a time with a completion wait, timeout and idle gap; stop pre-empts all.
module move_command_sequencer
  import move_command_sequencer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int DUP_WINDOW     = 2_500_000,
  parameter int GAP_CYCLES     = 250_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [CMD_W-1:0]       rx_cmd,
  output logic                   cmd_valid,
  output logic [CMD_W-1:0]       cmd_data,
  input  logic                   motor_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow,
  output logic                   timeout,
  output logic                   dup_drop
);

  localparam int DT_W = $clog2(DUP_WINDOW + 1);
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
  localparam int GP_W = cnt_w(GAP_CYCLES);
  localparam logic [DT_W-1:0] DUP_EXPIRED = DT_W'(DUP_WINDOW);
  localparam logic [DT_W-1:0] DT_ONE      = DT_W'(1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);
  localparam logic [GP_W-1:0] GAP_LAST    = GP_W'(GAP_CYCLES - 1);
  localparam logic [GP_W-1:0] GP_ONE      = GP_W'(1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_next_state;
  logic [CMD_W-1:0] r_cmd_data;
  logic [CMD_W-1:0] r_last_cmd;
  logic             r_last_vld;
  logic [DT_W-1:0]  r_dup_timer;
  logic [TO_W-1:0]  r_wait_cnt;
  logic [GP_W-1:0]  r_gap_cnt;
  logic             r_overflow;
  logic             w_stop, w_match, w_accept, w_push, w_pop;
  logic             w_full, w_empty;
  logic [CMD_W-1:0] w_head;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_stop   = rx_valid && (rx_cmd == CMD_STOP);
  assign w_match  = rx_valid && !w_stop && r_last_vld && (rx_cmd == r_last_cmd) &&
                    (r_dup_timer != DUP_EXPIRED);
  assign w_accept = rx_valid && !w_stop && !w_match;
  assign w_pop    = (r_state == S_IDLE) && !w_empty && !w_stop;
  assign w_push   = w_accept && (!w_full || w_pop);

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .i_clk   (clock),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_stop),
    .i_din   (rx_cmd),
    .o_head  (w_head),
    .o_count (queue_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Any match restarts the window, so a held button keeps being suppressed.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_last_cmd  <= '0;
      r_last_vld  <= 1'b0;
      r_dup_timer <= DUP_EXPIRED;
    end else begin
      if (w_accept) begin
        r_last_cmd <= rx_cmd;
        r_last_vld <= 1'b1;
      end
      if (w_accept || w_match)           r_dup_timer <= '0;
      else if (r_dup_timer != DUP_EXPIRED) r_dup_timer <= r_dup_timer + DT_ONE;
    end
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cmd_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_stop)     r_cmd_data <= CMD_STOP;
      else if (w_pop) r_cmd_data <= w_head;
      if (w_accept && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Counters sit at zero outside their own state, which clears them on entry.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state != S_WAIT_DONE)  r_wait_cnt <= '0;
      else if (r_wait_cnt != TO_LAST) r_wait_cnt <= r_wait_cnt + TO_ONE;
      if (r_state != S_GAP)        r_gap_cnt <= '0;
      else if (r_gap_cnt != GAP_LAST) r_gap_cnt <= r_gap_cnt + GP_ONE;
    end
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_stop) begin
      w_next_state = S_ISSUE;
    end else begin
      case (r_state)
        S_IDLE:      if (!w_empty) w_next_state = S_ISSUE;
        S_ISSUE:     w_next_state = S_WAIT_DONE;
        S_WAIT_DONE: if (motor_done || (r_wait_cnt == TO_LAST)) w_next_state = S_GAP;
        S_GAP:       if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
        default:     w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid = (r_state == S_ISSUE);
    busy      = (r_state != S_IDLE);
    timeout   = (r_state == S_WAIT_DONE) && (r_wait_cnt == TO_LAST) && !motor_done;
    dup_drop  = w_match;
    overflow  = r_overflow;
    cmd_data  = r_cmd_data;
  end

endmodule

// File: tb/tb_move_command_sequencer.sv
// Directed bench for move_command_sequencer: stimulus queues the expected issued
// commands, a negedge monitor pops and compares them on every cmd_valid.
module tb_move_command_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [11:0] rx_cmd = '0;
  logic        motor_done = 1'b0;
  logic        cmd_valid, busy, overflow, timeout, dup_drop;
  logic [11:0] cmd_data;
  logic [2:0]  queue_count;

  int checks = 0, errors = 0;
  int n_valid = 0, n_dup = 0, n_to = 0, base = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  always #5 clock = ~clock;

  move_command_sequencer #(
    .DEPTH(4), .DUP_WINDOW(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_cmd(rx_cmd),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .motor_done(motor_done),
    .busy(busy), .queue_count(queue_count), .overflow(overflow),
    .timeout(timeout), .dup_drop(dup_drop)
  );

  always @(negedge clock) begin
    if (cmd_valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got cmd_data=%03h, required no cmd_valid", cmd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cmd_data !== mon_exp) begin
          errors++;
          $display("FAIL issue_data: got %03h, required %03h", cmd_data, mon_exp);
        end
      end
    end
    if (dup_drop) n_dup++;
    if (timeout)  n_to++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [11:0] c, input bit expect_issue);
    rx_valid = 1'b1;
    rx_cmd   = c;
    if (expect_issue) exp_q.push_back(c);
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic done_pulse();
    motor_done = 1'b1;
    @(posedge clock); #1;
    motor_done = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (!busy && queue_count == 0) break;
      @(posedge clock); #1;
    end
    chk("drain_idle", {busy, queue_count}, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("reset_outputs", {cmd_valid, busy, overflow, timeout, dup_drop, queue_count, cmd_data}, 0);
    @(posedge clock); #3 reset_n = 1'b1;
    step(4);

    // 1: single command latency and gap
    send(12'h123, 1'b1);
    @(negedge clock);
    chk("t1_valid_n1", cmd_valid, 0);
    chk("t1_count_n1", queue_count, 1);
    @(negedge clock);
    chk("t1_valid_n2", cmd_valid, 1);
    chk("t1_data", cmd_data, 12'h123);
    chk("t1_busy_issue", busy, 1);
    @(posedge clock); #1;
    step(2);
    done_pulse();
    repeat (4) @(negedge clock);
    chk("t1_busy_gap_end", busy, 1);
    @(negedge clock);
    chk("t1_idle_after_gap", busy, 0);
    @(posedge clock); #1;

    // 2: held button duplicates, then resend after window expiry
    base = n_dup;
    send(12'h123, 1'b1);
    repeat (3) begin step(4); send(12'h123, 1'b0); end
    chk("t2_dup_drops", n_dup - base, 3);
    step(8);
    send(12'h123, 1'b1);
    chk("t2_resend_not_dropped", n_dup - base, 3);
    drain();

    // 3: five commands while waiting, FIFO overflow, in-order issue
    send(12'h001, 1'b1);
    step(2);
    send(12'h002, 1'b1);
    send(12'h003, 1'b1);
    send(12'h004, 1'b1);
    send(12'h005, 1'b1);
    send(12'h006, 1'b0);
    @(negedge clock);
    chk("t3_count_full", queue_count, 4);
    chk("t3_overflow", overflow, 1);
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) begin
      done_pulse();
      repeat (5) @(negedge clock);
      chk("t3_gap_quiet", cmd_valid, 0);
      @(negedge clock);
      chk("t3_issue_after_gap", cmd_valid, 1);
      @(posedge clock); #1;
    end
    done_pulse();
    drain();

    // 4: no motor_done, timeout then next command
    send(12'h0AA, 1'b1);
    step(3);
    send(12'h0BB, 1'b1);
    repeat (17) @(negedge clock);
    chk("t4_no_early_timeout", timeout, 0);
    @(negedge clock);
    chk("t4_timeout_pulse", timeout, 1);
    chk("t4_busy_at_timeout", busy, 1);
    repeat (5) @(negedge clock);
    chk("t4_gap_quiet", cmd_valid, 0);
    @(negedge clock);
    chk("t4_next_issue", cmd_valid, 1);
    chk("t4_next_data", cmd_data, 12'h0BB);
    @(posedge clock); #1;
    done_pulse();
    drain();

    // 5: stop during gap with three queued
    send(12'h101, 1'b1);
    step(2);
    send(12'h102, 1'b0);
    send(12'h103, 1'b0);
    send(12'h104, 1'b0);
    done_pulse();
    rx_valid = 1'b1;
    rx_cmd   = 12'h000;
    exp_q.push_back(12'h000);
    @(negedge clock);
    chk("t5_queued_before_stop", queue_count, 3);
    chk("t5_in_gap", busy, 1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
    @(negedge clock);
    chk("t5_flushed", queue_count, 0);
    chk("t5_stop_valid", cmd_valid, 1);
    chk("t5_stop_data", cmd_data, 12'h000);
    @(posedge clock); #1;
    done_pulse();
    drain();

    // 6: asynchronous reset in the middle of a move
    chk("t6_overflow_sticky", overflow, 1);
    send(12'h2AA, 1'b1);
    step(2);
    send(12'h2BB, 1'b0);
    @(negedge clock);
    chk("t6_pre_count", queue_count, 1);
    chk("t6_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {cmd_valid, busy, overflow, timeout, dup_drop, queue_count, cmd_data}, 0);
    @(posedge clock); #3 reset_n = 1'b1;
    base = n_valid;
    repeat (12) @(negedge clock);
    @(posedge clock); #1;
    chk("t6_quiet_after_reset", n_valid - base, 0);
    send(12'h2CC, 1'b1);
    @(negedge clock);
    chk("t6_new_valid_n1", cmd_valid, 0);
    @(negedge clock);
    chk("t6_new_valid_n2", cmd_valid, 1);
    chk("t6_new_data", cmd_data, 12'h2CC);
    @(posedge clock); #1;
    done_pulse();
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
